// File: rtl/display_scan_ctrl.sv
// Round-robin scan driver for the 4-digit stopwatch display: dead time, leading-zero
// blanking, per-digit blink and colon dot, with patterns latched once per frame.
module display_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_DIV    = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [6:0] dig0_seg,
   input  logic [6:0] dig1_seg,
   input  logic [6:0] dig2_seg,
   input  logic [6:0] dig3_seg,
   input  logic       lz_en,
   input  logic [3:0] blink_mask,
   input  logic       colon_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = $clog2(BLINK_DIV) + 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [6:0]    SEG_ZERO   = 7'b1000000;
   localparam logic [6:0]    SEG_OFF    = 7'h7F;

   logic [SW-1:0] slot_cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [6:0]    latch [4];

   logic       slot_last;
   logic       frame_end;
   logic       dead;
   logic       suppress;
   logic [3:0] an_nxt;
   logic [6:0] seg_nxt;
   logic       dp_nxt;

   always_comb begin
      slot_last = (slot_cnt == SLOT_LAST);
      frame_end = slot_last && (idx == 2'd3);
      dead      = (slot_cnt < BLANK_END);
      suppress  = (blink_mask[idx] && blink_phase) ||
                  ((idx == 2'd0) && lz_en && (latch[0] == SEG_ZERO));
      an_nxt    = 4'hF;
      seg_nxt   = SEG_OFF;
      dp_nxt    = 1'b1;
      if (!dead && !suppress) begin
         an_nxt  = ~(4'b1000 >> idx);
         seg_nxt = latch[idx];
         dp_nxt  = ~(colon_en && (idx == 2'd1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt    <= '0;
         idx         <= 2'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         latch[0]    <= SEG_OFF;
         latch[1]    <= SEG_OFF;
         latch[2]    <= SEG_OFF;
         latch[3]    <= SEG_OFF;
         an          <= 4'hF;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         frame_tick  <= 1'b0;
      end else if (!en) begin
         // held dark with latches following the inputs so a restart shows current data
         slot_cnt    <= '0;
         idx         <= 2'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         latch[0]    <= dig0_seg;
         latch[1]    <= dig1_seg;
         latch[2]    <= dig2_seg;
         latch[3]    <= dig3_seg;
         an          <= 4'hF;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         frame_tick  <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         if (slot_last) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
         if (frame_end) begin
            latch[0] <= dig0_seg;
            latch[1] <= dig1_seg;
            latch[2] <= dig2_seg;
            latch[3] <= dig3_seg;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment stopwatch display.
- Takes four pre-decoded segment patterns (min_l, min_r, sec_l, sec_r) from the segment lookup stage.
- Drives the shared seg/dp lines and the per-digit anodes in round-robin order.
- Provides per-slot dead time (anti-ghosting), leading-zero blanking, per-digit blink and a colon dot.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Constraint: REFRESH_DIV >= 2.
- BLANK_CYCLES, 1000: dead-time cycles at the start of each slot, with all anodes off. Constraint: 1 <= BLANK_CYCLES < REFRESH_DIV.
- BLINK_DIV, 125: full scan frames per blink half-period. Constraint: BLINK_DIV >= 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable. Low means display dark and counters held.
- dig0_seg, input, 7: active-low pattern for min_l (leftmost digit).
- dig1_seg, input, 7: active-low pattern for min_r.
- dig2_seg, input, 7: active-low pattern for sec_l.
- dig3_seg, input, 7: active-low pattern for sec_r.
- lz_en, input, 1: blank digit 0 when its pattern is the zero code.
- blink_mask, input, 4: bit i set means digit i blinks.
- colon_en, input, 1: light dp on digit 1.
- seg, output, 7: active-low segment lines, registered.
- dp, output, 1: active-low decimal point, registered.
- an, output, 4: active-low anodes, registered. Digit i drives an[3-i].
- frame_tick, output, 1: one-cycle pulse at the start of each scan frame.

Behaviour:
- Reset (rst_n low, async): an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. Internal state: slot_cnt=0, idx=0, blink_phase=0, blink_cnt=0. Pattern latches are loaded with 7'h7F.
- Slot counter: slot_cnt counts 0..REFRESH_DIV-1.
  - On terminal count, slot_cnt wraps to 0 and idx advances 0→1→2→3→0.
  - A frame is 4 slots, i.e. 4*REFRESH_DIV cycles.
- Frame end condition: slot_cnt==REFRESH_DIV-1 && idx==3. In that cycle:
  - all four dig*_seg inputs are captured into the pattern latches, so a frame never tears mid-scan;
  - frame_tick is registered high for exactly the next cycle;
  - blink_cnt increments. On reaching BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- Pattern latch updates: latches change only at frame end, or on every cycle while en=0.
- Per-cycle decode, computed from the current slot_cnt/idx and registered into outputs (1-cycle latency):
  - Dead time: slot_cnt < BLANK_CYCLES gives an=1111, seg=7F, dp=1.
  - Suppression: otherwise the digit is suppressed if (blink_mask[idx] && blink_phase) or (idx==0 && lz_en && latch0==7'b1000000). Suppressed means an=1111, seg=7F, dp=1.
  - Otherwise: an = active-low one-hot at bit 3-idx; seg = latch[idx]; dp = ~(colon_en && idx==1).
- Exactly one anode is low at any time outside dead time and suppression. Never more than one.
- en=0 (synchronous):
  - Next cycle: outputs go dark and frame_tick=0.
  - slot_cnt, idx, blink_cnt and blink_phase clear to 0.
  - Latches track the inputs.
- en 0→1: scan starts at slot 0 of digit 0 with the latches already current. No frame_tick on that first cycle; the first frame_tick follows the first frame end.
- Simultaneous events: frame end with en falling means en=0 wins (counters clear, no tick). Input pattern changes mid-frame are not shown until the next frame.
- Reset mid-scan: all outputs go dark immediately (asynchronously). Scanning restarts from digit 0 after release.
- Width rules: slot_cnt is $clog2(REFRESH_DIV) bits; blink_cnt is $clog2(BLINK_DIV)+1 bits. No overflow is possible given the constraints.

Test Plan:
Use REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=2 for all scenarios.
- Basic scan: en=1, patterns 7'h40/7'h79/7'h24/7'h30, masks 0.
  - Per 8-cycle slot: 2 cycles an=1111, then 6 cycles an=0111 with seg=40.
  - Following slots: an=1011 with seg=79, an=1101 with seg=24, an=1110 with seg=30.
  - Pattern repeats every 32 cycles; frame_tick pulses once per 32 cycles.
- Frame coherency: change dig2_seg from 24 to 12 during slot 1.
  - Slot 2 of the current frame still shows 24.
  - The next frame shows 12.
- Leading zero: lz_en=1, dig0_seg=7'h40 → slot 0 keeps an=1111 throughout.
  - Same with dig0_seg=7'h79 → an=0111 is driven as normal.
- Blink: blink_mask=4'b0011.
  - Digits 0/1 are dark for 2 frames (64 cycles), lit for 2 frames, alternating.
  - Digits 2/3 are unaffected throughout.
- Colon: colon_en=1 → dp=0 only during the lit window of digit 1; dp=1 elsewhere, including dead time.
- Enable/reset: drop en mid-slot 2 → dark next cycle.
  - Re-raise en → scan restarts at digit 0 with fresh patterns.
  - Assert rst_n=0 asynchronously mid-lit window → an=1111 and seg=7F without waiting for a clk edge.
